inst_fetch_queue: RTL
=====================

Name: inst_fetch_queue

Overview:
- Decoupling instruction queue between the instruction-fetch stage and the instruction-decode stage.
- Accepts {pc, instruction} pairs from fetch and presents them in order to decode.
- Back-pressures fetch through freezeOut when full; holds its head entry while decode stalls.
- Discards all queued entries when a branch is taken (flush).

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- PTR_W, 2, pointer width; must equal log2(DEPTH).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset; clears the queue.
- inPc  input  32  pc of the fetched instruction (pc+4 value produced by fetch).
- inInstruction  input  32  fetched instruction word.
- inValid  input  1  fetch presents a valid entry this cycle.
- freezeOut  output  1  queue full; drives the fetch stage freeze input.
- flush  input  1  branch taken; discard everything.
- idStall  input  1  decode cannot consume the head this cycle (hazard).
- outPc  output  32  head entry pc; 0 when outValid=0.
- outInstruction  output  32  head entry instruction; 0 (NOP) when outValid=0.
- outValid  output  1  head entry valid.
- fullCycles  output  32  statistics counter (see Optional Feature).
- flushedEntries  output  32  statistics counter (see Optional Feature).

Behaviour:
- Storage: DEPTH x 64-bit entry array, wrPtr and rdPtr (PTR_W bits), count (PTR_W+1 bits).
- reset asserted (async): wrPtr=rdPtr=count=0; entry array and counters cleared; outValid=0, outPc=0, outInstruction=0, freezeOut=0.
- Reset mid-operation discards all entries with no partial writes.
- push = inValid & (count != DEPTH) & ~flush. On push, the entry is written at wrPtr and wrPtr increments, wrapping DEPTH-1 -> 0.
- pop = outValid & ~idStall & ~flush. On pop, rdPtr increments with the same wrap.
- count: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Push while full is ignored. Pop while empty is impossible because outValid=0.
- Combinational outputs:
  - outValid = (count != 0).
  - outPc/outInstruction = entry[rdPtr] when outValid, else 0.
  - freezeOut = (count == DEPTH).
- Latency: a push into an empty queue appears at the outputs on the next cycle (1-cycle fall-through latency).
- At full, push and pop cannot occur together, because freezeOut stops fetch. Once the pop makes count=DEPTH-1, freezeOut deasserts.
- flush (synchronous, highest priority after reset): wrPtr=rdPtr=count=0 at the next edge. Any push and pop in that cycle are cancelled. The next cycle shows outValid=0 and freezeOut=0.
- flush with idStall: flush wins.
- idStall with outValid: the head entry and outputs hold stable, and push still proceeds if not full.

Optional Feature:
- Macro: FETCH_QUEUE_STATS_EN.
- With the macro defined:
  - fullCycles increments each cycle freezeOut=1.
  - flushedEntries adds the current count on every flush cycle.
  - Both counters wrap at 2^32 and are cleared by reset only, not by flush.
- Without the macro: both counter registers are omitted and the outputs are tied to 0. The ports remain in both builds.

Test Plan:
- Reset, then push pc=4 instr=0xA1, 0xA2, 0xA3 on consecutive cycles with idStall=1 -> count=3, outPc=4 and outInstruction=0xA1 held, freezeOut=0.
- Fill to DEPTH=4 with idStall=1 -> freezeOut=1. A 5th push (0xA5) is ignored. Release idStall for one cycle -> pop 0xA1, freezeOut=0 next cycle, contents 0xA2..0xA4.
- Continuous push and pop for 10 entries with idStall=0 -> outputs follow inputs 1 cycle later, count stays 1, pointers wrap past 3 -> 0 correctly, order preserved.
- Three entries queued, assert flush with inValid=1 and idStall=0 -> next cycle outValid=0, outPc=0, outInstruction=0, count=0. The flush-cycle input is not stored. With FETCH_QUEUE_STATS_EN, flushedEntries=3.
- Assert reset asynchronously mid-cycle with 2 entries queued -> outputs go to 0 immediately, without waiting for a clock edge. After release, the first push is seen 1 cycle later.
- With FETCH_QUEUE_STATS_EN, hold the queue full for 5 cycles -> fullCycles=5. Without the macro -> fullCycles=0 and flushedEntries=0 throughout.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - decoupling {pc, instruction} queue between fetch and decode
//
// Purpose: in-order FIFO of fetched {pc, instruction} pairs with 1-cycle
// fall-through latency. It back-pressures fetch when full and discards
// everything on a taken branch (flush).
//
// Optional feature macro: FETCH_QUEUE_STATS_EN. When it is defined, the
// fullCycles and flushedEntries statistics counters are built. When it is
// undefined, both outputs are tied to 0.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous active-high reset, clears the queue
//   inPc           in   [31:0] pc of the fetched instruction
//   inInstruction  in   [31:0] fetched instruction word
//   inValid        in   fetch presents an entry this cycle
//   freezeOut      out  queue full, freezes fetch
//   flush          in   branch taken, discard all entries
//   idStall        in   decode cannot consume the head this cycle
//   outPc          out  [31:0] head pc, 0 when empty
//   outInstruction out  [31:0] head instruction, 0 (NOP) when empty
//   outValid       out  head entry valid
//   fullCycles     out  [31:0] cycles spent full (stats build only)
//   flushedEntries out  [31:0] entries discarded by flushes (stats build only)

module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] inPc,
    input  logic [31:0] inInstruction,
    input  logic        inValid,
    output logic        freezeOut,
    input  logic        flush,
    input  logic        idStall,
    output logic [31:0] outPc,
    output logic [31:0] outInstruction,
    output logic        outValid,
    output logic [31:0] fullCycles,
    output logic [31:0] flushedEntries
);

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [63:0]      entries [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   count;
    logic [63:0]      head;
    logic             push;
    logic             pop;

    assign outValid  = (count != '0);
    assign freezeOut = (count == FULL_COUNT);

    // Flush cancels both transfers in the same cycle.
    assign push = inValid & ~freezeOut & ~flush;
    assign pop  = outValid & ~idStall & ~flush;

    assign head           = entries[rdPtr];
    assign outPc          = outValid ? head[63:32] : 32'd0;
    assign outInstruction = outValid ? head[31:0]  : 32'd0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                entries[wrPtr] <= {inPc, inInstruction};
                // DEPTH is a power of two, so the natural pointer overflow is the wrap.
                wrPtr          <= wrPtr + PTR_ONE;
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] fullCyclesReg;
    logic [31:0] flushedEntriesReg;

    // Only reset clears the statistics; flush is one of the events being counted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fullCyclesReg     <= '0;
            flushedEntriesReg <= '0;
        end else begin
            if (freezeOut) begin
                fullCyclesReg <= fullCyclesReg + 32'd1;
            end
            if (flush) begin
                flushedEntriesReg <= flushedEntriesReg + 32'(count);
            end
        end
    end

    assign fullCycles     = fullCyclesReg;
    assign flushedEntries = flushedEntriesReg;
`else
    assign fullCycles     = 32'd0;
    assign flushedEntries = 32'd0;
`endif

endmodule
